tilt_marker_draw: RTL and testbench



---
 rtl/tilt_marker_draw.sv | 213 +++++++++++++++++++++
 tb/tb_tilt_marker_draw.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tilt_marker_draw.sv
// tilt_marker_draw: frame_manager write source that rasterises a centre
// crosshair, NUM_CH tilt markers and a trail of recent channel-0 positions.
//
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   write_source_sel   frame_manager source select; outputs are 'z unless == SOURCE_ID
//   write_awaited      frame request
//   tilt_amount_x/y    per-channel unsigned magnitudes (AMT_W bits each)
//   tilt_direction_x/y per-channel sign, 1 = negative
//   write_active       pixel valid this cycle
//   write_color_data   pixel colour (0 when transparent)
//   write_transparent  pixel carries no drawing
//   write_x_addr/y     current column / row
module tilt_marker_draw #(
    parameter int unsigned SOURCE_SEL_ADDRW  = 3,
    parameter int unsigned SOURCE_ID         = 0,
    parameter int unsigned DRAW_WIDTH        = 160,
    parameter int unsigned DRAW_HEIGHT       = 120,
    parameter int unsigned DRAW_WIDTH_ADDRW  = $clog2(DRAW_WIDTH),
    parameter int unsigned DRAW_HEIGHT_ADDRW = $clog2(DRAW_HEIGHT),
    parameter int unsigned COLOR_DEPTH       = 9,
    parameter int unsigned NUM_CH            = 2,
    parameter int unsigned AMT_W             = 4,
    parameter int unsigned TILT_SCALE        = 1,
    parameter int unsigned MARK_SIZE         = 10,
    parameter int unsigned TRAIL_DEPTH       = 4,
    parameter logic [NUM_CH*COLOR_DEPTH-1:0] MARK_COLORS = {9'h038, 9'h1c0},
    parameter logic [COLOR_DEPTH-1:0]        TRAIL_COLOR = 9'h0a4,
    parameter logic [COLOR_DEPTH-1:0]        CROSS_COLOR = 9'h1ff
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
    input  logic                         write_awaited,
    input  logic [NUM_CH*AMT_W-1:0]      tilt_amount_x,
    input  logic [NUM_CH-1:0]            tilt_direction_x,
    input  logic [NUM_CH*AMT_W-1:0]      tilt_amount_y,
    input  logic [NUM_CH-1:0]            tilt_direction_y,
    output logic                         write_active,
    output logic [COLOR_DEPTH-1:0]       write_color_data,
    output logic                         write_transparent,
    output logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
    output logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr
);

    localparam int unsigned XW    = DRAW_WIDTH_ADDRW;
    localparam int unsigned YW    = DRAW_HEIGHT_ADDRW;
    localparam int unsigned CNT_W = $clog2(TRAIL_DEPTH + 1);
    localparam logic [XW-1:0] HALF_X = XW'(DRAW_WIDTH / 2);
    localparam logic [YW-1:0] HALF_Y = YW'(DRAW_HEIGHT / 2);
    localparam logic [XW-1:0] LAST_X = XW'(DRAW_WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(DRAW_HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, LATCH, WRITE_ACTIVE, TRAIL_PUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    col_q, col_d;
    logic [YW-1:0]    row_q, row_d;
    logic             latch_en, push_en;
    logic             selected, active_c;
    logic [XW-1:0]    cx_c [NUM_CH];
    logic [YW-1:0]    cy_c [NUM_CH];
    logic [XW-1:0]    cx_q [NUM_CH];
    logic [YW-1:0]    cy_q [NUM_CH];
    logic [XW-1:0]    tx_q [TRAIL_DEPTH];
    logic [YW-1:0]    ty_q [TRAIL_DEPTH];
    logic [CNT_W-1:0] trail_cnt_q;
    logic [COLOR_DEPTH-1:0] pix_color_c;
    logic             pix_transparent_c;

    // Offset a centre by the scaled signed tilt and keep the whole box on screen.
    function automatic logic [15:0] clamp_centre(input logic [AMT_W-1:0] amt, input logic neg,
                                                 input int unsigned dim);
        logic signed [15:0] off, half, lo, hi, c;
        off  = signed'(16'(amt) << TILT_SCALE);
        half = signed'(16'(dim / 2));
        lo   = signed'(16'(MARK_SIZE + 1));
        hi   = signed'(16'(dim - 1 - MARK_SIZE));
        c    = neg ? half - off : half + off;
        if (c < lo)      c = lo;
        else if (c > hi) c = hi;
        return 16'(c);
    endfunction

    // True when p lies in [c-lo_ext, c+hi_ext]; written without subtraction to avoid underflow.
    function automatic logic in_span(input logic [15:0] p, input logic [15:0] c,
                                     input int unsigned lo_ext, input int unsigned hi_ext);
        return ((p + 16'(lo_ext)) >= c) && (p <= (c + 16'(hi_ext)));
    endfunction

    assign selected = (write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));
    assign active_c = (state_q == WRITE_ACTIVE);

    // Candidate centres from the live inputs; only captured in LATCH.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cx_c[i] = XW'(clamp_centre(tilt_amount_x[i*AMT_W +: AMT_W], tilt_direction_x[i], DRAW_WIDTH));
            cy_c[i] = YW'(clamp_centre(tilt_amount_y[i*AMT_W +: AMT_W], tilt_direction_y[i], DRAW_HEIGHT));
        end
    end

    // Pixel classification; later assignments win, so layers run lowest priority first.
    always_comb begin
        pix_color_c       = '0;
        pix_transparent_c = 1'b1;
        if (in_span(16'(col_q), 16'(HALF_X), 1, 0) || in_span(16'(row_q), 16'(HALF_Y), 1, 0)) begin
            pix_color_c       = CROSS_COLOR;
            pix_transparent_c = 1'b0;
        end
        for (int k = 0; k < TRAIL_DEPTH; k++) begin
            if ((CNT_W'(k) < trail_cnt_q) &&
                in_span(16'(col_q), 16'(tx_q[k]), 1, 0) && in_span(16'(row_q), 16'(ty_q[k]), 1, 0)) begin
                pix_color_c       = TRAIL_COLOR;
                pix_transparent_c = 1'b0;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_span(16'(col_q), 16'(cx_q[i]), MARK_SIZE + 1, MARK_SIZE) &&
                in_span(16'(row_q), 16'(cy_q[i]), MARK_SIZE + 1, MARK_SIZE)) begin
                pix_color_c       = MARK_COLORS[i*COLOR_DEPTH +: COLOR_DEPTH];
                pix_transparent_c = 1'b0;
            end
        end
    end

    // Next-state and raster counter logic.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        latch_en = 1'b0;
        push_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (write_awaited && selected) state_d = LATCH;
            end
            LATCH: begin
                latch_en = 1'b1;
                col_d    = '0;
                row_d    = '0;
                state_d  = WRITE_ACTIVE;
            end
            WRITE_ACTIVE: begin
                if (!selected) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else if (col_q == LAST_X) begin
                    col_d = '0;
                    if (row_q == LAST_Y) begin
                        row_d   = '0;
                        state_d = TRAIL_PUSH;
                    end else begin
                        row_d = row_q + YW'(1);
                    end
                end else begin
                    col_d = col_q + XW'(1);
                end
            end
            TRAIL_PUSH: begin
                push_en = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters, latched centres and trail history.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            trail_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cx_q[i] <= HALF_X;
                cy_q[i] <= HALF_Y;
            end
            for (int k = 0; k < TRAIL_DEPTH; k++) begin
                tx_q[k] <= HALF_X;
                ty_q[k] <= HALF_Y;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (latch_en) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    cx_q[i] <= cx_c[i];
                    cy_q[i] <= cy_c[i];
                end
            end
            if (push_en) begin
                tx_q[0] <= cx_q[0];
                ty_q[0] <= cy_q[0];
                for (int k = 1; k < TRAIL_DEPTH; k++) begin
                    tx_q[k] <= tx_q[k-1];
                    ty_q[k] <= ty_q[k-1];
                end
                if (trail_cnt_q != CNT_W'(TRAIL_DEPTH)) trail_cnt_q <= trail_cnt_q + CNT_W'(1);
            end
        end
    end

    // Shared bus: release every output when another source is selected.
    assign write_active      = selected ? active_c : 1'bz;
    assign write_transparent = selected ? (active_c ? pix_transparent_c : 1'b1) : 1'bz;
    assign write_color_data  = selected ? (active_c ? pix_color_c : '0) : 'z;
    assign write_x_addr      = selected ? col_q : 'z;
    assign write_y_addr      = selected ? row_q : 'z;

endmodule

// File: tb/tb_tilt_marker_draw.sv
// Scoreboard bench for tilt_marker_draw: stimulus pushes every expected pixel
// of a frame into a queue; a monitor pops one entry per active output cycle.
module tb_tilt_marker_draw;

    localparam int W = 64, H = 48, NCH = 2, AW = 4, SCALE = 1, MS = 10, TD = 4, CD = 9;
    localparam logic [NCH*CD-1:0] MCOL = {9'h038, 9'h1c0};
    localparam int TRAILC = 'h0a4, CROSSC = 'h1ff;

    logic clk = 1'b0;
    logic resetN;
    logic [1:0] sel;
    logic awaited;
    logic [NCH*AW-1:0] amx, amy;
    logic [NCH-1:0] dxs, dys;
    logic w_active, w_tr;
    logic [CD-1:0] w_color;
    logic [5:0] wx, wy;

    tilt_marker_draw #(
        .SOURCE_SEL_ADDRW(2), .SOURCE_ID(0), .DRAW_WIDTH(W), .DRAW_HEIGHT(H)
    ) dut (
        .clk(clk), .resetN(resetN), .write_source_sel(sel), .write_awaited(awaited),
        .tilt_amount_x(amx), .tilt_direction_x(dxs), .tilt_amount_y(amy), .tilt_direction_y(dys),
        .write_active(w_active), .write_color_data(w_color), .write_transparent(w_tr),
        .write_x_addr(wx), .write_y_addr(wy)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int col; bit tr; } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, act_cnt = 0;
    int ax[NCH], ay[NCH];
    bit sx[NCH], sy[NCH];
    int fcx[NCH], fcy[NCH];
    int trail_x[$], trail_y[$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // A released (or idle-low) line must never read as a driven 1.
    task automatic chk_released(string name, logic v);
        total++;
        if (!(v === 1'bz || v === 1'b0)) begin
            bad++;
            $display("FAIL %s got=%b exp=z", name, v);
        end
    endtask

    function automatic int centre(int amt, bit neg, int dim);
        int c;
        c = neg ? dim / 2 - amt * (2 ** SCALE) : dim / 2 + amt * (2 ** SCALE);
        if (c < MS + 1) c = MS + 1;
        if (c > dim - 1 - MS) c = dim - 1 - MS;
        return c;
    endfunction

    function automatic exp_t expect_pixel(int x, int y);
        exp_t e;
        bit found = 0;
        e.x = x; e.y = y; e.col = 0; e.tr = 1;
        for (int i = 0; i < NCH && !found; i++)
            if (x >= fcx[i] - 1 - MS && x <= fcx[i] + MS && y >= fcy[i] - 1 - MS && y <= fcy[i] + MS) begin
                e.col = int'(MCOL[i*CD +: CD]); found = 1;
            end
        for (int k = 0; k < trail_x.size() && !found; k++)
            if ((x == trail_x[k] || x == trail_x[k] - 1) && (y == trail_y[k] || y == trail_y[k] - 1)) begin
                e.col = TRAILC; found = 1;
            end
        if (!found && (x == W / 2 - 1 || x == W / 2 || y == H / 2 - 1 || y == H / 2)) begin
            e.col = CROSSC; found = 1;
        end
        e.tr = !found;
        return e;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < NCH; i++) begin
            amx[i*AW +: AW] = AW'(ax[i]);
            amy[i*AW +: AW] = AW'(ay[i]);
            dxs[i] = sx[i];
            dys[i] = sy[i];
        end
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < NCH; i++) begin ax[i] = 0; ay[i] = 0; sx[i] = 0; sy[i] = 0; end
        apply_inputs();
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NCH; i++) begin
            ax[i] = $urandom_range(0, 15); ay[i] = $urandom_range(0, 15);
            sx[i] = 1'($urandom_range(0, 1)); sy[i] = 1'($urandom_range(0, 1));
        end
        apply_inputs();
    endtask

    task automatic wait_pix(int x, int y);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (w_active === 1'b1 && wx == 6'(x) && wy == 6'(y)) return;
        end
        total++; bad++;
        $display("FAIL wait_pix timeout at x=%0d y=%0d", x, y);
    endtask

    // mode 0 normal, 1 tilt change at stop_row, 2 deselect at stop_row,
    // 3 reset at stop_row, 4 normal plus a request pulse while in DONE.
    task automatic run_frame(int mode, int stop_row);
        int n;
        for (int i = 0; i < NCH; i++) begin
            fcx[i] = centre(ax[i], sx[i], W);
            fcy[i] = centre(ay[i], sy[i], H);
        end
        n = (mode == 2 || mode == 3) ? stop_row * W + 1 : W * H;
        for (int p = 0; p < n; p++) sb.push_back(expect_pixel(p % W, p / W));
        act_cnt = 0;
        @(negedge clk) awaited = 1'b1;
        @(negedge clk) awaited = 1'b0;
        chk("latch_not_active", 32'(w_active), 32'd0);
        @(negedge clk);
        chk("first_pixel", {19'd0, w_active, wx, wy}, {19'd0, 1'b1, 6'd0, 6'd0});
        if (mode == 1 || mode == 2 || mode == 3) wait_pix(0, stop_row);
        if (mode == 1) rand_inputs();
        if (mode == 2) begin
            sel = 2'd1;
            @(negedge clk);
            chk_released("desel_active", w_active);
            chk_released("desel_transparent", w_tr);
            sel = 2'd0;
            @(negedge clk);
            chk("abort_idle", 32'(w_active), 32'd0);
            chk("abort_sb_drained", sb.size(), 0);
        end else if (mode == 3) begin
            resetN = 1'b0;
            #1;
            chk("midreset_active", 32'(w_active), 32'd0);
            @(negedge clk) resetN = 1'b1;
            trail_x.delete(); trail_y.delete();
            chk("midreset_sb_drained", sb.size(), 0);
        end else begin
            wait_pix(W - 1, H - 1);
            @(negedge clk);
            @(negedge clk) if (mode == 4) awaited = 1'b1;
            @(negedge clk) awaited = 1'b0;
            repeat (8) @(negedge clk);
            chk("frame_len", act_cnt, W * H);
            chk("idle_after_frame", 32'(w_active), 32'd0);
            chk("sb_drained", sb.size(), 0);
            trail_x.push_front(fcx[0]); trail_y.push_front(fcy[0]);
            if (trail_x.size() > TD) begin void'(trail_x.pop_back()); void'(trail_y.pop_back()); end
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: one scoreboard entry per active output cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (w_active === 1'b1) begin
            act_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL extra_pixel got x=%0d y=%0d", wx, wy);
            end else begin
                e = sb.pop_front();
                if ({wx, wy, w_color, w_tr} !== {6'(e.x), 6'(e.y), 9'(e.col), e.tr}) begin
                    bad++;
                    $display("FAIL pixel got x=%0d y=%0d c=%h t=%b exp x=%0d y=%0d c=%h t=%b",
                             wx, wy, w_color, w_tr, e.x, e.y, e.col, e.tr);
                end
            end
        end
    end

    initial begin
        resetN = 1'b0; sel = 2'd0; awaited = 1'b0;
        zero_inputs();
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(w_active), 32'd0);
        chk("rst_transparent", 32'(w_tr), 32'd1);
        chk("rst_color", 32'(w_color), 32'd0);
        chk("rst_addr", {20'd0, wx, wy}, 32'd0);
        resetN = 1'b1;
        @(negedge clk) sel = 2'd2;
        @(negedge clk);
        chk_released("unsel_active", w_active);
        chk_released("unsel_transparent", w_tr);
        sel = 2'd0;
        @(negedge clk);

        run_frame(4, 0);
        zero_inputs(); ax[0] = 15; sx[0] = 0; ay[1] = 15; sy[1] = 1; apply_inputs();
        run_frame(0, 0);
        for (int a = 1; a <= 4; a++) begin
            zero_inputs(); ax[0] = a; apply_inputs();
            run_frame(0, 0);
        end
        zero_inputs();
        run_frame(0, 0);
        run_frame(0, 0);
        rand_inputs(); run_frame(1, 20);
        rand_inputs(); run_frame(2, 5);
        rand_inputs(); run_frame(0, 0);
        rand_inputs(); run_frame(3, 10);
        rand_inputs(); run_frame(0, 0);
        repeat (2) begin rand_inputs(); run_frame(0, 0); end

        chk("sb_empty_end", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
